conv_fetch_arbiter: RTL and testbench

- Sequences operand fetch for the CONV engine during one convolution pass.
- Arbitrates CONV's ifm_read and wgt_read requests onto a single shared synchronous SRAM read port, which holds IFM and weights in separate regions.
- Generates wrapping addresses and returns data with per-source valid strobes.
- Tracks the pass lifecycle from start_conv to end_conv.

---
 rtl/conv_ctrl_pkg.sv | 40 ++++
 rtl/rr_arb2.sv | 38 +++
 rtl/conv_fetch_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_conv_fetch_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: shared encodings for the CONV fetch arbiter.
// Holds the pass FSM state codes, source IDs used to index request/grant
// vectors, and the saturating pending-request bookkeeping helper.
package conv_ctrl_pkg;

    // Pass lifecycle states (kept as plain constants for legacy tools).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Source IDs; also the bit position of each source in req/gnt vectors.
    localparam logic SRC_IFM = 1'b0;
    localparam logic SRC_WGT = 1'b1;

    // Outstanding-request counter per source.
    localparam int PEND_W = 2;
    typedef logic [PEND_W-1:0] pend_t;
    localparam pend_t PEND_MAX = '1;

    typedef struct packed {
        pend_t cnt;
        logic  drop;
    } pend_upd_t;

    // Next pending count for one source. A new read that arrives while the
    // counter is full and the source is not being served cannot be held,
    // so it is dropped and reported.
    function automatic pend_upd_t pend_update(input pend_t p, input logic rd, input logic gnt);
        pend_upd_t u;
        u.drop = rd && !gnt && (p == PEND_MAX);
        u.cnt  = p;
        if (rd && !gnt && !u.drop) begin
            u.cnt = p + pend_t'(1);
        end else if (!rd && gnt) begin
            u.cnt = p - pend_t'(1);
        end
        return u;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
// A lone requester is always granted. When both request, the source named
// by the priority register wins and priority passes to the other source.
// Priority starts at the weight source after reset.
module rr_arb2
    import conv_ctrl_pkg::*;
(
    input  logic       clk2,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    logic r_prio;
    logic w_both;

    assign w_both = i_req[0] & i_req[1];

    // Grant select: priority holder on contention, otherwise the requester.
    always_comb begin
        o_gnt = i_req;
        if (w_both) begin
            o_gnt         = 2'b00;
            o_gnt[r_prio] = 1'b1;
        end
    end

    // Priority flips only when a contended grant is actually issued.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= SRC_WGT;
        end else if (i_advance && w_both) begin
            r_prio <= ~r_prio;
        end
    end

endmodule

// File: rtl/conv_fetch_arbiter.sv
// conv_fetch_arbiter: operand fetch sequencer for one CONV pass.
// Merges ifm_read / wgt_read onto a single synchronous SRAM read port,
// walks each source's region with a wrapping pointer, and returns data
// with per-source strobes two cycles after an uncontended read.
// Optional stall counter built when CONV_ARB_PERF_CNT_EN is defined;
// otherwise stall_cycles is tied to zero.
module conv_fetch_arbiter
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned IFM_WIDTH    = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned IFM_BASE     = 0,
    parameter int unsigned IFM_LEN      = 12288,
    parameter int unsigned WGT_BASE     = 12288,
    parameter int unsigned WGT_LEN      = 216
) (
    input  logic                    clk2,
    input  logic                    rst_n,
    input  logic                    start_conv,
    input  logic                    end_conv,
    input  logic                    ifm_read,
    input  logic                    wgt_read,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [IFM_WIDTH-1:0]    mem_rdata,
    output logic [IFM_WIDTH-1:0]    ifm,
    output logic                    ifm_valid,
    output logic [WEIGHT_WIDTH-1:0] wgt,
    output logic                    wgt_valid,
    output logic                    busy,
    output logic                    err_ovf,
    output logic [31:0]             stall_cycles
);

    localparam logic [ADDR_WIDTH-1:0] L_IFM_BASE = ADDR_WIDTH'(IFM_BASE);
    localparam logic [ADDR_WIDTH-1:0] L_WGT_BASE = ADDR_WIDTH'(WGT_BASE);
    localparam logic [ADDR_WIDTH-1:0] L_IFM_LAST = ADDR_WIDTH'(IFM_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] L_WGT_LAST = ADDR_WIDTH'(WGT_LEN - 1);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ifm_ptr;
    logic [ADDR_WIDTH-1:0] r_wgt_ptr;
    pend_t                 r_pend_ifm;
    pend_t                 r_pend_wgt;
    logic                  r_err_ovf;
    logic                  r_ret_vld;
    logic                  r_ret_src;
    logic [IFM_WIDTH-1:0]  r_ifm;
    logic [WEIGHT_WIDTH-1:0] r_wgt;
    logic                  r_ifm_vld;
    logic                  r_wgt_vld;

    logic                  w_run;
    logic                  w_active;
    logic                  w_start;
    logic                  w_ifm_rd;
    logic                  w_wgt_rd;
    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    pend_upd_t             w_upd_ifm;
    pend_upd_t             w_upd_wgt;
    logic                  w_drain_done;

    assign w_run    = (r_state == ST_RUN);
    assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_start  = (r_state == ST_IDLE) && start_conv;

    // New reads are only accepted while running; DRAIN serves backlog only.
    assign w_ifm_rd = w_run & ifm_read;
    assign w_wgt_rd = w_run & wgt_read;

    assign w_req[SRC_IFM] = w_active & ((r_pend_ifm != '0) | w_ifm_rd);
    assign w_req[SRC_WGT] = w_active & ((r_pend_wgt != '0) | w_wgt_rd);

    rr_arb2 u_arb (
        .clk2      (clk2),
        .rst_n     (rst_n),
        .i_req     (w_req),
        .i_advance (w_active),
        .o_gnt     (w_gnt)
    );

    assign w_upd_ifm = pend_update(r_pend_ifm, w_ifm_rd, w_gnt[SRC_IFM]);
    assign w_upd_wgt = pend_update(r_pend_wgt, w_wgt_rd, w_gnt[SRC_WGT]);

    // With both backlogs empty nothing can be granted this cycle, and any
    // grant from the previous cycle is captured on this same edge, so the
    // pass can close without waiting for the strobe itself.
    assign w_drain_done = (r_pend_ifm == '0) && (r_pend_wgt == '0);

    // SRAM port: driven straight from the grant so a read costs no extra cycle.
    assign mem_req = |w_gnt;

    // Address of the granted source; zero when the port is idle.
    always_comb begin
        mem_addr = '0;
        if (w_gnt[SRC_IFM]) begin
            mem_addr = L_IFM_BASE + r_ifm_ptr;
        end else if (w_gnt[SRC_WGT]) begin
            mem_addr = L_WGT_BASE + r_wgt_ptr;
        end
    end

    // Pass lifecycle: IDLE -> RUN on start, RUN -> DRAIN on end, back to IDLE once empty.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start_conv)   r_state <= ST_RUN;
                ST_RUN:   if (end_conv)     r_state <= ST_DRAIN;
                ST_DRAIN: if (w_drain_done) r_state <= ST_IDLE;
                default:                    r_state <= ST_IDLE;
            endcase
        end
    end

    // Pointers, backlog counters and the sticky overflow flag; all restart on a new pass.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            r_ifm_ptr  <= '0;
            r_wgt_ptr  <= '0;
            r_pend_ifm <= '0;
            r_pend_wgt <= '0;
            r_err_ovf  <= 1'b0;
        end else if (w_start) begin
            r_ifm_ptr  <= '0;
            r_wgt_ptr  <= '0;
            r_pend_ifm <= '0;
            r_pend_wgt <= '0;
            r_err_ovf  <= 1'b0;
        end else if (w_active) begin
            r_pend_ifm <= w_upd_ifm.cnt;
            r_pend_wgt <= w_upd_wgt.cnt;
            if (w_gnt[SRC_IFM]) begin
                r_ifm_ptr <= (r_ifm_ptr == L_IFM_LAST) ? '0 : r_ifm_ptr + ADDR_WIDTH'(1);
            end
            if (w_gnt[SRC_WGT]) begin
                r_wgt_ptr <= (r_wgt_ptr == L_WGT_LAST) ? '0 : r_wgt_ptr + ADDR_WIDTH'(1);
            end
            if (w_upd_ifm.drop || w_upd_wgt.drop) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    // Remember who owns the word the SRAM returns next cycle.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            r_ret_vld <= 1'b0;
            r_ret_src <= SRC_IFM;
        end else begin
            r_ret_vld <= mem_req;
            r_ret_src <= w_gnt[SRC_WGT];
        end
    end

    // Capture returned data into the owning source's register and strobe it.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            r_ifm     <= '0;
            r_wgt     <= '0;
            r_ifm_vld <= 1'b0;
            r_wgt_vld <= 1'b0;
        end else begin
            r_ifm_vld <= r_ret_vld && (r_ret_src == SRC_IFM);
            r_wgt_vld <= r_ret_vld && (r_ret_src == SRC_WGT);
            if (r_ret_vld && (r_ret_src == SRC_IFM)) begin
                r_ifm <= mem_rdata;
            end
            if (r_ret_vld && (r_ret_src == SRC_WGT)) begin
                r_wgt <= mem_rdata;
            end
        end
    end

    assign ifm       = r_ifm;
    assign wgt       = r_wgt;
    assign ifm_valid = r_ifm_vld;
    assign wgt_valid = r_wgt_vld;
    assign busy      = w_active;
    assign err_ovf   = r_err_ovf;

`ifdef CONV_ARB_PERF_CNT_EN
    logic [31:0] r_stall;
    logic        w_stall;

    // A requester left unserved means the port was oversubscribed this cycle.
    assign w_stall = w_active && ((w_req & ~w_gnt) != 2'b00);

    // Saturating stall counter, restarted with each pass.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_start) begin
            r_stall <= '0;
        end else if (w_stall && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_fetch_arbiter.sv
// Directed bench for conv_fetch_arbiter: a per-cycle vector table for the
// basic pass (single read, contention, start-while-busy, end with backlog),
// then hand sequences for pointer wrap, overflow and mid-pass reset.
module tb_conv_fetch_arbiter;

    logic        clk2 = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_conv = 1'b0;
    logic        end_conv = 1'b0;
    logic        ifm_read = 1'b0;
    logic        wgt_read = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  ifm;
    logic        ifm_valid;
    logic [7:0]  wgt;
    logic        wgt_valid;
    logic        busy;
    logic        err_ovf;
    logic [31:0] stall_cycles;

    int checks = 0;
    int failures = 0;

`ifdef CONV_ARB_PERF_CNT_EN
    localparam int EXP_STALL = 17;
`else
    localparam int EXP_STALL = 0;
`endif

    conv_fetch_arbiter dut (
        .clk2         (clk2),
        .rst_n        (rst_n),
        .start_conv   (start_conv),
        .end_conv     (end_conv),
        .ifm_read     (ifm_read),
        .wgt_read     (wgt_read),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .ifm          (ifm),
        .ifm_valid    (ifm_valid),
        .wgt          (wgt),
        .wgt_valid    (wgt_valid),
        .busy         (busy),
        .err_ovf      (err_ovf),
        .stall_cycles (stall_cycles)
    );

    always #5 clk2 = ~clk2;

    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Synchronous SRAM model: word appears the cycle after the request.
    always @(posedge clk2) begin
        if (mem_req) mem_rdata <= memf(mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drv(input logic st, input logic en, input logic ir, input logic wr);
        @(negedge clk2);
        start_conv = st;
        end_conv   = en;
        ifm_read   = ir;
        wgt_read   = wr;
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 20) begin
            drv(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic        st, en, ir, wr;
        logic        ereq;
        logic [15:0] eaddr;
        logic        eiv;
        logic [7:0]  eifm;
        logic        ewv;
        logic [7:0]  ewgt;
        logic        ebusy;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic en, input logic ir, input logic wr,
                                input logic ereq, input int eaddr,
                                input logic eiv, input int ia,
                                input logic ewv, input int wa, input logic ebusy);
        vec_t v;
        v.st = st; v.en = en; v.ir = ir; v.wr = wr;
        v.ereq  = ereq;
        v.eaddr = 16'(eaddr);
        v.eiv   = eiv;
        v.eifm  = memf(16'(ia));
        v.ewv   = ewv;
        v.ewgt  = memf(16'(wa));
        v.ebusy = ebusy;
        return v;
    endfunction

    vec_t tbl [0:23];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int nv;
        int niv;
        int nwv;
        logic [7:0] first_w;
        logic [7:0] last_w;

        //          st en ir wr  req addr    iv ia    wv wa     busy
        tbl[0]  = mk(1, 1, 0, 0,  0, 0,      0, 0,    0, 0,     0); // start+end in IDLE: start wins
        tbl[1]  = mk(0, 0, 0, 1,  1, 12288,  0, 0,    0, 0,     1);
        tbl[2]  = mk(0, 0, 0, 0,  0, 0,      0, 0,    0, 0,     1);
        tbl[3]  = mk(0, 0, 0, 0,  0, 0,      0, 0,    1, 12288, 1);
        tbl[4]  = mk(0, 0, 0, 0,  0, 0,      0, 0,    0, 0,     1);
        tbl[5]  = mk(0, 0, 1, 1,  1, 12289,  0, 0,    0, 0,     1); // W
        tbl[6]  = mk(0, 0, 1, 1,  1, 0,      0, 0,    0, 0,     1); // I
        tbl[7]  = mk(0, 0, 1, 1,  1, 12290,  0, 0,    1, 12289, 1); // W
        tbl[8]  = mk(0, 0, 1, 1,  1, 1,      1, 0,    0, 0,     1); // I
        tbl[9]  = mk(0, 0, 0, 0,  1, 12291,  0, 0,    1, 12290, 1); // W
        tbl[10] = mk(1, 0, 0, 0,  1, 2,      1, 1,    0, 0,     1); // I, start ignored
        tbl[11] = mk(0, 0, 0, 0,  1, 12292,  0, 0,    1, 12291, 1); // W
        tbl[12] = mk(0, 0, 0, 0,  1, 3,      1, 2,    0, 0,     1); // I
        tbl[13] = mk(0, 0, 0, 0,  0, 0,      0, 0,    1, 12292, 1);
        tbl[14] = mk(0, 0, 0, 0,  0, 0,      1, 3,    0, 0,     1);
        tbl[15] = mk(0, 0, 1, 1,  1, 4,      0, 0,    0, 0,     1);
        tbl[16] = mk(0, 0, 1, 1,  1, 12293,  0, 0,    0, 0,     1);
        tbl[17] = mk(0, 0, 1, 0,  1, 5,      1, 4,    0, 0,     1);
        tbl[18] = mk(0, 1, 1, 0,  1, 12294,  0, 0,    1, 12293, 1); // end, 2 ifm pending
        tbl[19] = mk(0, 0, 0, 1,  1, 6,      1, 5,    0, 0,     1); // DRAIN, read ignored
        tbl[20] = mk(0, 0, 1, 0,  1, 7,      0, 0,    1, 12294, 1);
        tbl[21] = mk(0, 0, 0, 1,  0, 0,      1, 6,    0, 0,     1);
        tbl[22] = mk(0, 0, 1, 1,  0, 0,      1, 7,    0, 0,     0); // busy low 2 after last grant
        tbl[23] = mk(0, 0, 0, 0,  0, 0,      0, 0,    0, 0,     0);

        // Reset state
        #2 rst_n = 1'b0;
        @(negedge clk2);
        #1;
        chk("rst mem_req",   32'(mem_req),   32'd0);
        chk("rst mem_addr",  32'(mem_addr),  32'd0);
        chk("rst ifm",       32'(ifm),       32'd0);
        chk("rst wgt",       32'(wgt),       32'd0);
        chk("rst ifm_valid", 32'(ifm_valid), 32'd0);
        chk("rst wgt_valid", 32'(wgt_valid), 32'd0);
        chk("rst busy",      32'(busy),      32'd0);
        chk("rst err_ovf",   32'(err_ovf),   32'd0);
        chk("rst stall",     stall_cycles,   32'd0);
        rst_n = 1'b1;

        // Pass 1: vector table
        for (int i = 0; i < 24; i++) begin
            drv(tbl[i].st, tbl[i].en, tbl[i].ir, tbl[i].wr);
            chk($sformatf("row%0d mem_req", i),   32'(mem_req),   32'(tbl[i].ereq));
            chk($sformatf("row%0d mem_addr", i),  32'(mem_addr),  32'(tbl[i].eaddr));
            chk($sformatf("row%0d ifm_valid", i), 32'(ifm_valid), 32'(tbl[i].eiv));
            chk($sformatf("row%0d wgt_valid", i), 32'(wgt_valid), 32'(tbl[i].ewv));
            chk($sformatf("row%0d busy", i),      32'(busy),      32'(tbl[i].ebusy));
            chk($sformatf("row%0d err_ovf", i),   32'(err_ovf),   32'd0);
            if (tbl[i].eiv) chk($sformatf("row%0d ifm", i), 32'(ifm), 32'(tbl[i].eifm));
            if (tbl[i].ewv) chk($sformatf("row%0d wgt", i), 32'(wgt), 32'(tbl[i].ewgt));
        end

        // Pass 2: 217 weight reads, pointer wraps after 216
        drv(1'b1, 1'b0, 1'b0, 1'b0);
        nv = 0;
        first_w = 8'h00;
        last_w  = 8'h00;
        for (int i = 0; i < 220; i++) begin
            drv(1'b0, 1'b0, 1'b0, i < 217);
            if (i < 217) begin
                chk($sformatf("wrap req %0d", i),  32'(mem_req),  32'd1);
                chk($sformatf("wrap addr %0d", i), 32'(mem_addr), 32'(12288 + (i % 216)));
            end
            if (wgt_valid) begin
                nv++;
                if (nv == 1)   first_w = wgt;
                if (nv == 217) last_w  = wgt;
            end
        end
        chk("wrap valid count", 32'(nv), 32'd217);
        chk("wrap first word", 32'(first_w), 32'(memf(16'd12288)));
        chk("wrap 217th word", 32'(last_w), 32'(first_w));
        drv(1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle("wrap pass idle");

        // Pass 3: both sources continuous -> overflow and dropped requests
        drv(1'b1, 1'b0, 1'b0, 1'b0);
        niv = 0;
        nwv = 0;
        for (int c = 0; c < 25; c++) begin
            drv(1'b0, c == 12, c < 12, c < 12);
            if (c < 12) chk($sformatf("ovf c%0d", c), 32'(err_ovf), 32'(c >= 7));
            niv += int'(ifm_valid);
            nwv += int'(wgt_valid);
        end
        chk("ovf ifm valids", 32'(niv), 32'd9);
        chk("ovf wgt valids", 32'(nwv), 32'd9);
        chk("ovf sticky", 32'(err_ovf), 32'd1);
        chk("ovf pass idle", 32'(busy), 32'd0);
        chk("stall_cycles", stall_cycles, 32'(EXP_STALL));

        // Pass 4: reset in the middle of a pass
        drv(1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b1);
        chk("p4 ovf cleared", 32'(err_ovf), 32'd0);
        chk("p4 w addr", 32'(mem_addr), 32'd12288);
        drv(1'b0, 1'b0, 1'b1, 1'b0);
        chk("p4 i addr", 32'(mem_addr), 32'd0);
        drv(1'b0, 1'b0, 1'b1, 1'b1);
        chk("p4 wgt_valid", 32'(wgt_valid), 32'd1);
        chk("p4 contended addr", 32'(mem_addr), 32'd12289);
        drv(1'b0, 1'b0, 1'b0, 1'b0);
        chk("p4 ifm_valid", 32'(ifm_valid), 32'd1);
        chk("p4 ifm", 32'(ifm), 32'(memf(16'd0)));
        #1 rst_n = 1'b0;
        #1;
        chk("arst mem_req",   32'(mem_req),   32'd0);
        chk("arst mem_addr",  32'(mem_addr),  32'd0);
        chk("arst ifm",       32'(ifm),       32'd0);
        chk("arst wgt",       32'(wgt),       32'd0);
        chk("arst ifm_valid", 32'(ifm_valid), 32'd0);
        chk("arst busy",      32'(busy),      32'd0);
        drv(1'b0, 1'b0, 1'b1, 1'b1);
        chk("arst hold req",   32'(mem_req),   32'd0);
        chk("arst wgt_valid",  32'(wgt_valid), 32'd0);
        #2 rst_n = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post rst no valid", 32'(ifm_valid | wgt_valid), 32'd0);
        drv(1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b1, 1'b1);
        chk("restart w first", 32'(mem_addr), 32'd12288);
        drv(1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart i req",  32'(mem_req),  32'd1);
        chk("restart i addr", 32'(mem_addr), 32'd0);
        drv(1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart wgt_valid", 32'(wgt_valid), 32'd1);
        chk("restart wgt", 32'(wgt), 32'(memf(16'd12288)));
        drv(1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart ifm_valid", 32'(ifm_valid), 32'd1);
        chk("restart ifm", 32'(ifm), 32'(memf(16'd0)));
        drv(1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle("restart pass idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
